// File: rtl/mem_store_checker_pkg.sv
// Shared types and default constants for the store-bus checker and its trace FIFO.
// The verdict FSM encoding is fixed here so debug tooling can decode state_dbg.
package mem_check_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [31:0] DEF_PASS_ADDR      = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA      = 32'd7;
    localparam logic [31:0] DEF_ALLOW_ADDR     = 32'd80;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
    localparam int unsigned DEF_DEPTH          = 8;

endpackage

// File: rtl/mem_store_checker_trace_fifo.sv
// Show-ahead trace FIFO of store entries with a sticky overflow flag.
// Occupancy comes from the difference of two log2(DEPTH)+1 bit pointers.
module trace_fifo
    import mem_check_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [63:0] din,
    input  logic        pop,
    output logic [63:0] head,
    output logic        empty,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         overflow_q, overflow_d;
    trace_entry_t mem_q [DEPTH];
    trace_entry_t mem_d [DEPTH];

    logic [AW:0]  count;
    logic         full;
    logic         do_pop;
    logic         do_push;

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == (AW+1)'(DEPTH));
        empty    = (count == '0);
        // A pop frees the slot this cycle, so a full FIFO may still accept a push.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = trace_entry_t'(din);
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end

        head = empty ? 64'd0 : 64'(mem_q[rd_ptr_q[AW-1:0]]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign overflow = overflow_q;

endmodule

// File: rtl/mem_store_checker.sv
// Store-bus checker: classifies CPU stores into PASS / FAIL / TIMEOUT verdicts
// and records every store seen during the run in a trace FIFO.
module mem_store_checker
    import mem_check_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
    parameter logic [31:0] ALLOW_ADDR     = DEF_ALLOW_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned DEPTH          = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [31:0] fail_adr,
    output logic [31:0] fail_data,
    output logic [31:0] cycle_cnt,
    output logic [15:0] store_cnt,
    output logic        trace_valid,
    output logic [31:0] trace_adr,
    output logic [31:0] trace_data,
    input  logic        trace_rd,
    output logic        trace_overflow,
    output logic [1:0]  state_dbg
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;
    logic [31:0] fail_adr_q, fail_adr_d;
    logic [31:0] fail_data_q, fail_data_d;

    logic        store_acc;
    logic        is_pass;
    logic        is_fail;
    logic        fifo_empty;
    logic [63:0] fifo_head;

    always_comb begin
        // X/Z on the strobe must never count as a store.
        store_acc = (state_q == RUN) && (memwrite === 1'b1);
        is_pass   = (dataadr == PASS_ADDR) && (writedata == PASS_DATA);
        is_fail   = !is_pass && (dataadr != ALLOW_ADDR);

        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        store_cnt_d = store_cnt_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;

        if (state_q == RUN) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            if (store_acc && store_cnt_q != 16'hFFFF) begin
                store_cnt_d = store_cnt_q + 16'd1;
            end
            // A terminating store outranks the timeout in the same cycle.
            if (store_acc && is_pass) begin
                state_d = PASS;
            end else if (store_acc && is_fail) begin
                state_d     = FAIL;
                fail_adr_d  = dataadr;
                fail_data_d = writedata;
            end else if (cycle_cnt_q == TIMEOUT_LAST) begin
                state_d = TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cycle_cnt_q <= '0;
            store_cnt_q <= '0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            store_cnt_q <= store_cnt_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
        end
    end

    trace_fifo #(
        .DEPTH(DEPTH)
    ) u_trace_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (store_acc),
        .din      ({dataadr, writedata}),
        .pop      (trace_rd),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .overflow (trace_overflow)
    );

    assign done        = (state_q != RUN);
    assign pass        = (state_q == PASS);
    assign fail        = (state_q == FAIL);
    assign timeout     = (state_q == TIMEOUT);
    assign fail_adr    = fail_adr_q;
    assign fail_data   = fail_data_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign store_cnt   = store_cnt_q;
    assign trace_valid = !fifo_empty;
    assign trace_adr   = fifo_head[63:32];
    assign trace_data  = fifo_head[31:0];
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_store_checker.sv
// Self-checking bench for mem_store_checker: a verdict/queue model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_store_checker;

    localparam int TO = 16;
    localparam int DP = 4;

    localparam int V_RUN = 0, V_PASS = 1, V_FAIL = 2, V_TIMEOUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_adr, fail_data, cycle_cnt;
    logic [15:0] store_cnt;
    logic        trace_valid;
    logic [31:0] trace_adr, trace_data;
    logic        trace_rd;
    logic        trace_overflow;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    mem_store_checker #(
        .PASS_ADDR(32'd84),
        .PASS_DATA(32'd7),
        .ALLOW_ADDR(32'd80),
        .TIMEOUT_CYCLES(TO),
        .DEPTH(DP)
    ) dut (
        .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .fail_adr(fail_adr), .fail_data(fail_data),
        .cycle_cnt(cycle_cnt), .store_cnt(store_cnt), .trace_valid(trace_valid),
        .trace_adr(trace_adr), .trace_data(trace_data), .trace_rd(trace_rd),
        .trace_overflow(trace_overflow), .state_dbg(state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: verdict, counters, captured store, and the trace as a plain queue.
    int          m_v;
    int          m_cycles;
    int          m_stores;
    logic [31:0] m_fadr, m_fdata;
    bit          m_ovf;
    bit          m_ready = 1'b0;
    logic [63:0] exp_q[$];

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_v = V_RUN; m_cycles = 0; m_stores = 0;
            m_fadr = 0; m_fdata = 0; m_ovf = 0;
            exp_q.delete();
            m_ready = 1'b1;
        end else if (m_ready) begin
            bit popped;
            bit st;
            popped = (trace_rd === 1'b1) && (exp_q.size() > 0);
            st = (m_v == V_RUN) && (memwrite === 1'b1);
            if (st) begin
                if (exp_q.size() < DP || popped) exp_q.push_back({dataadr, writedata});
                else m_ovf = 1;
                if (m_stores < 65535) m_stores++;
            end
            if (popped) void'(exp_q.pop_front());
            if (m_v == V_RUN) begin
                if (st && dataadr == 32'd84 && writedata == 32'd7) m_v = V_PASS;
                else if (st && dataadr != 32'd80) begin
                    m_v = V_FAIL; m_fadr = dataadr; m_fdata = writedata;
                end else if (m_cycles == TO - 1) m_v = V_TIMEOUT;
                m_cycles++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("cmp_done", 32'(done), 32'(m_v != V_RUN));
            chk("cmp_pass", 32'(pass), 32'(m_v == V_PASS));
            chk("cmp_fail", 32'(fail), 32'(m_v == V_FAIL));
            chk("cmp_timeout", 32'(timeout), 32'(m_v == V_TIMEOUT));
            chk("cmp_state", 32'(state_dbg), 32'(m_v));
            chk("cmp_fail_adr", fail_adr, m_fadr);
            chk("cmp_fail_data", fail_data, m_fdata);
            chk("cmp_cycle_cnt", cycle_cnt, 32'(m_cycles));
            chk("cmp_store_cnt", 32'(store_cnt), 32'(m_stores));
            chk("cmp_overflow", 32'(trace_overflow), 32'(m_ovf));
            chk("cmp_trace_valid", 32'(trace_valid), 32'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("cmp_trace_adr", trace_adr, exp_q[0][63:32]);
                chk("cmp_trace_data", trace_data, exp_q[0][31:0]);
            end
        end
    end

    // One clock: drive inputs now (just after a falling edge), return at the next falling edge.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rd);
        memwrite = mw; dataadr = a; writedata = d; trace_rd = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b1, 32'd84, 32'd7, 1'b1);
        rst = 1'b0;
        memwrite = 1'b0; trace_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic pop_chk(input string name, input logic [31:0] a, input logic [31:0] d);
        chk({name, "_valid"}, 32'(trace_valid), 32'd1);
        chk({name, "_adr"}, trace_adr, a);
        chk({name, "_data"}, trace_data, d);
        step(1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; trace_rd = 1'b0;
        do_reset();

        // Reset state
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_verdicts", 32'({pass, fail, timeout}), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_counts", cycle_cnt | 32'(store_cnt), 32'd0);
        chk("rst_fail_capture", fail_adr | fail_data, 32'd0);
        chk("rst_trace", trace_adr | trace_data | 32'(trace_valid) | 32'(trace_overflow), 32'd0);

        // Scratch stores then pass store; trace read back in order
        step(1'b1, 32'd80, 32'd1, 1'b0);
        step(1'b1, 32'd80, 32'd2, 1'b0);
        chk("t1_not_done", 32'(done), 32'd0);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_store_cnt", 32'(store_cnt), 32'd3);
        pop_chk("t1_pop0", 32'd80, 32'd1);
        pop_chk("t1_pop1", 32'd80, 32'd2);
        pop_chk("t1_pop2", 32'd84, 32'd7);
        chk("t1_empty", 32'(trace_valid), 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        chk("t1_empty_pop", 32'(trace_valid), 32'd0);

        // Wrong data at the pass address fails; later pass store ignored
        do_reset();
        step(1'b1, 32'd84, 32'd6, 1'b0);
        chk("t2_fail", 32'(fail), 32'd1);
        chk("t2_fail_adr", fail_adr, 32'd84);
        chk("t2_fail_data", fail_data, 32'd6);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t2_still_fail", 32'({pass, fail}), 32'b01);
        chk("t2_store_cnt", 32'(store_cnt), 32'd1);
        chk("t2_cycle_frozen", cycle_cnt, 32'd1);

        // Store to an unrelated address
        do_reset();
        step(1'b1, 32'h100, 32'hDEAD, 1'b0);
        chk("t3_fail", 32'(fail), 32'd1);
        chk("t3_fail_adr", fail_adr, 32'h100);
        chk("t3_fail_data", fail_data, 32'hDEAD);

        // Timeout after TO idle cycles
        do_reset();
        idle(TO - 1);
        chk("t4_no_timeout_yet", 32'(timeout), 32'd0);
        idle(1);
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_cycle_cnt", cycle_cnt, 32'd16);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t4_frozen_cycle", cycle_cnt, 32'd16);
        chk("t4_no_store", 32'(store_cnt), 32'd0);
        chk("t4_no_push", 32'(trace_valid), 32'd0);

        // Pass store on the final cycle beats the timeout
        do_reset();
        idle(TO - 1);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t5_pass", 32'(pass), 32'd1);
        chk("t5_timeout", 32'(timeout), 32'd0);
        chk("t5_cycle_cnt", cycle_cnt, 32'd16);

        // Overflow: six stores into a four-entry FIFO keep the first four
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 32'd80, 32'(i), 1'b0);
        chk("t6_overflow", 32'(trace_overflow), 32'd1);
        chk("t6_store_cnt", 32'(store_cnt), 32'd6);
        for (int i = 0; i < 4; i++) pop_chk("t6_pop", 32'd80, 32'(i));
        chk("t6_drained", 32'(trace_valid), 32'd0);

        // Push and pop together while full: no overflow, occupancy unchanged
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'd80, 32'(10 + i), 1'b0);
        chk("t7_full_no_ovf", 32'(trace_overflow), 32'd0);
        step(1'b1, 32'd80, 32'd14, 1'b1);
        chk("t7_pushpop_no_ovf", 32'(trace_overflow), 32'd0);
        for (int i = 0; i < 4; i++) pop_chk("t7_pop", 32'd80, 32'(11 + i));
        chk("t7_drained", 32'(trace_valid), 32'd0);

        // Push and pop together on an empty FIFO performs only the push
        do_reset();
        step(1'b1, 32'd80, 32'd9, 1'b1);
        chk("t8_valid", 32'(trace_valid), 32'd1);
        chk("t8_head", trace_data, 32'd9);

        // Reset after a FAIL returns everything to reset values, then a clean pass
        do_reset();
        step(1'b1, 32'd5, 32'd5, 1'b0);
        chk("t9_fail", 32'(fail), 32'd1);
        do_reset();
        chk("t9_rst_state", 32'(state_dbg), 32'd0);
        chk("t9_rst_flags", 32'({done, pass, fail, timeout, trace_valid, trace_overflow}), 32'd0);
        chk("t9_rst_regs", fail_adr | fail_data | cycle_cnt | 32'(store_cnt), 32'd0);
        step(1'b1, 32'd84, 32'd7, 1'b0);
        chk("t9_pass", 32'(pass), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_store_checker.md
# mem_store_checker

Synthesizable store-bus checker that sits directly downstream of the pipelined MIPS top and consumes its data-memory write port (memwrite, dataadr, writedata). It classifies every store against the end-of-program convention: a store of the pass value to the pass address ends the run as PASS; any store to an address other than the scratch address ends it as FAIL; no verdict before the cycle limit ends it as TIMEOUT. It also buffers the store trace in a small FIFO for readout by a bench or a debug UART.

## Interface
- PASS_ADDR, 32'd84: address whose store can signal success
- PASS_DATA, 32'd7: data value that signals success at PASS_ADDR
- ALLOW_ADDR, 32'd80: scratch address; stores here are legal and non-terminal
- TIMEOUT_CYCLES, 4096: run cycles before TIMEOUT; must be ≥ 2
- DEPTH, 8: trace FIFO entries; power of two, ≥ 2

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- memwrite  in  1  store strobe from the CPU top
- dataadr  in  32  store address
- writedata  in  32  store data
- done  out  1  verdict reached (pass | fail | timeout)
- pass, fail, timeout  out  1 each  one-hot verdict, sticky
- fail_adr, fail_data  out  32 each  store that caused FAIL
- cycle_cnt  out  32  cycles spent in RUN
- store_cnt  out  16  stores accepted in RUN, saturating at 16'hFFFF
- trace_valid  out  1  FIFO non-empty
- trace_adr, trace_data  out  32 each  FIFO head, show-ahead
- trace_rd  in  1  pop head; ignored when empty
- trace_overflow  out  1  sticky; a store was dropped because the FIFO was full

## Operation
- States: RUN, PASS, FAIL, TIMEOUT. A cycle with rst = 1 forces RUN. There are no other transitions into RUN.
- In RUN, every cycle: cycle_cnt += 1.
- A store is accepted in RUN when memwrite === 1. X or Z on memwrite is not a store.
- Classification of an accepted store, in priority order:
  - dataadr == PASS_ADDR and writedata == PASS_DATA → PASS.
  - dataadr != ALLOW_ADDR → FAIL; capture fail_adr and fail_data.
  - Otherwise stay in RUN.
- A store to PASS_ADDR with the wrong data is therefore FAIL.
- TIMEOUT: in RUN, when cycle_cnt == TIMEOUT_CYCLES-1 and there is no terminating store that cycle, go to TIMEOUT.
- A terminating store in the same cycle as the timeout wins over the timeout.
- Terminal states hold until rst. No further counting, pushes, or captures happen in a terminal state. FIFO pops still work.
- Every accepted store in RUN is pushed to the FIFO, including the terminating store, and store_cnt increments.
- FIFO full:
  - Push without pop: the entry is dropped and trace_overflow is set.
  - Push with pop in the same cycle: both happen and occupancy is unchanged.
- FIFO empty: a pop is ignored. A push and pop in the same cycle on an empty FIFO performs only the push.

## Timing
- All outputs are registered and updated on the rising edge.
- Reset values: state RUN; done, pass, fail, timeout, trace_valid, trace_overflow = 0; cycle_cnt, store_cnt = 0; fail_adr, fail_data, trace_adr, trace_data = 0.
- Verdict latency is 1 cycle: a store sampled at edge N gives done = 1 after edge N.
- A push at edge N gives trace_valid = 1 after edge N. The head data is valid in the same cycle.
- A pop at edge N presents the next entry, or trace_valid = 0, after edge N.
- Reset mid-run or after a verdict clears everything on the next edge, including the FIFO contents. Inputs in the reset cycle are ignored.

## Structure
- Package mem_check_pkg holds:
  - the state enum (RUN, PASS, FAIL, TIMEOUT);
  - the trace entry struct {adr[31:0], data[31:0]};
  - the default constants 84, 7, 80.
- Sub-module trace_fifo: parameterized DEPTH, 64-bit entry, show-ahead, synchronous reset, with full/empty flags and occupancy derived from a log2(DEPTH)+1 pointer difference.
- The top level contains the FSM, the counters and the verdict capture.

## Test plan
- Stores (80,1), (80,2), then (84,7) → pass = 1 one cycle after the third store; store_cnt = 3; FIFO pops return (80,1), (80,2), (84,7), then trace_valid = 0.
- Store (84,6) → fail = 1, fail_adr = 84, fail_data = 6; a later store (84,7) changes nothing.
- Store (0x100, 0xDEAD) → fail = 1, fail_adr = 0x100.
- No stores, TIMEOUT_CYCLES = 16 → timeout = 1 after edge 16; cycle_cnt = 16. With a (84,7) store on the final cycle → pass wins, timeout = 0.
- DEPTH = 4; 6 stores to 80 with no pops → trace_overflow = 1 and the FIFO holds the first 4. Push and pop together while full → occupancy stays 4 and overflow is not newly caused.
- Assert rst for one cycle after a FAIL → all outputs return to reset values and state is RUN; then (84,7) → pass.
